// File: rtl/fp_unpack_norm.sv
// Unpacks an IEEE-754 single/double operand into sign, unbiased exponent and significand; flags specials.
// Latency 1 cycle (7 for denormals: capture plus 6 shift steps); the result is held in DONE until out_ready.
module fp_unpack_norm (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] operand,
  input  logic        db,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        s,
  output logic [12:0] e,
  output logic [52:0] f,
  output logic [5:0]  lz,
  output logic        ZERO,
  output logic        INF,
  output logic        NAN,
  output logic        SNAN
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t      state;
  logic [2:0]  step;
  logic        dbl;

  // Field extraction; single-precision fraction is left-aligned in the 52-bit field
  logic [10:0] ex_raw;
  logic [51:0] frac;
  logic        sign_raw;
  logic        ex_zero;
  logic        ex_ones;
  logic        frac_zero;
  logic [12:0] e_unb;

  assign ex_raw    = db ? operand[62:52] : {3'b000, operand[30:23]};
  assign frac      = db ? operand[51:0] : {operand[22:0], 29'd0};
  assign sign_raw  = db ? operand[63] : operand[31];
  assign ex_zero   = (ex_raw == 11'd0);
  assign ex_ones   = db ? (&operand[62:52]) : (&operand[30:23]);
  assign frac_zero = (frac == 52'd0);
  assign e_unb     = {2'b00, ex_raw} - (db ? 13'd1023 : 13'd127);

  // One binary-search step: shift by 32,16,...,1 when the top 'amount' bits are clear
  logic [5:0]  amount;
  logic [52:0] top_mask;
  logic        top_clear;
  logic [52:0] f_next;
  logic [5:0]  lz_next;
  logic [12:0] e_denorm;

  assign amount    = 6'd32 >> step;
  assign top_mask  = ~({53{1'b1}} >> amount);
  assign top_clear = ((f & top_mask) == 53'd0);
  assign f_next    = top_clear ? (f << amount) : f;
  assign lz_next   = top_clear ? (lz + amount) : lz;
  assign e_denorm  = (dbl ? (13'd1 - 13'd1023) : (13'd1 - 13'd127)) - {7'd0, lz_next};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      step  <= 3'd0;
      dbl   <= 1'b0;
      s     <= 1'b0;
      e     <= 13'd0;
      f     <= 53'd0;
      lz    <= 6'd0;
      ZERO  <= 1'b0;
      INF   <= 1'b0;
      NAN   <= 1'b0;
      SNAN  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dbl  <= db;
            s    <= sign_raw;
            lz   <= 6'd0;
            step <= 3'd0;
            ZERO <= ex_zero & frac_zero;
            INF  <= ex_ones & frac_zero;
            NAN  <= ex_ones & ~frac_zero;
            SNAN <= ex_ones & ~frac_zero & ~frac[51];
            if (ex_zero && frac_zero) begin
              e     <= 13'd0;
              f     <= 53'd0;
              state <= DONE;
            end else if (ex_zero) begin
              e     <= 13'd0;
              f     <= {1'b0, frac};
              state <= NORM;
            end else begin
              e     <= e_unb;
              f     <= {1'b1, frac};
              state <= DONE;
            end
          end
        end
        NORM: begin
          f  <= f_next;
          lz <= lz_next;
          if (step == 3'd5) begin
            e     <= e_denorm;
            state <= DONE;
          end else begin
            step <= step + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_unpack_norm.sv
// Directed-vector bench for fp_unpack_norm: latency, field decode, classes, backpressure, reset mid-shift.
module tb_fp_unpack_norm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] operand = 64'd0;
  logic        db = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        s;
  logic [12:0] e;
  logic [52:0] f;
  logic [5:0]  lz;
  logic        ZERO, INF, NAN, SNAN;

  int checks = 0;
  int errors = 0;

  localparam logic [52:0] ONE = 53'h10000000000000;

  fp_unpack_norm dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .operand(operand), .db(db), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .e(e), .f(f), .lz(lz), .ZERO(ZERO), .INF(INF), .NAN(NAN), .SNAN(SNAN)
  );

  always #5 clk = ~clk;

  // Presents one operand in IDLE and counts edges (accept edge = 1) until out_valid
  task automatic run_op(input logic d, input logic [63:0] op, output int lat);
    db = d;
    operand = op;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_handshake: got valid/ready=%b required 01", {out_valid, in_ready});
    end
    checks++;
    if ({s, e, f, lz, ZERO, INF, NAN, SNAN} !== 77'd0) begin
      errors++;
      $display("FAIL reset_fields: got s=%b e=%h f=%h lz=%0d flags=%b required all zero",
               s, e, f, lz, {ZERO, INF, NAN, SNAN});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_normal();
    logic        d   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [63:0] op  [5] = '{64'h3F800000, 64'hFFFFFFFF3F800000, 64'h3FF0000000000000,
                             64'h4000000000000000, 64'hC0200000};
    logic [76:0] exp [5] = '{{1'b0, 13'd0, ONE, 6'd0, 4'b0000},
                             {1'b0, 13'd0, ONE, 6'd0, 4'b0000},
                             {1'b0, 13'd0, ONE, 6'd0, 4'b0000},
                             {1'b0, 13'd1, ONE, 6'd0, 4'b0000},
                             {1'b1, 13'd1, 53'h14000000000000, 6'd0, 4'b0000}};
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(d[i], op[i], lat);
      checks++;
      if (lat !== 1) begin
        errors++;
        $display("FAIL normal_latency[%0d]: got %0d cycles required 1", i, lat);
      end
      checks++;
      if ({s, e, f, lz, ZERO, INF, NAN, SNAN} !== exp[i]) begin
        errors++;
        $display("FAIL normal_fields[%0d]: got s=%b e=%h f=%h lz=%0d flags=%b required %h",
                 i, s, e, f, lz, {ZERO, INF, NAN, SNAN}, exp[i]);
      end
      release_result();
    end
  endtask

  task automatic test_denormal();
    logic        d   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [63:0] op  [4] = '{64'h1, 64'h1, 64'h00400000, 64'h0008000000000000};
    logic [76:0] exp [4] = '{{1'b0, 13'h1BCE, ONE, 6'd52, 4'b0000},
                             {1'b0, 13'h1F6B, ONE, 6'd23, 4'b0000},
                             {1'b0, 13'h1F81, ONE, 6'd1,  4'b0000},
                             {1'b0, 13'h1C01, ONE, 6'd1,  4'b0000}};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(d[i], op[i], lat);
      checks++;
      if (lat !== 7) begin
        errors++;
        $display("FAIL denorm_latency[%0d]: got %0d cycles required 7", i, lat);
      end
      checks++;
      if ({s, e, f, lz, ZERO, INF, NAN, SNAN} !== exp[i]) begin
        errors++;
        $display("FAIL denorm_fields[%0d]: got s=%b e=%h f=%h lz=%0d flags=%b required %h",
                 i, s, e, f, lz, {ZERO, INF, NAN, SNAN}, exp[i]);
      end
      release_result();
    end
  endtask

  task automatic test_specials();
    logic        d   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [63:0] op  [5] = '{64'h80000000, 64'h7F800000, 64'h7FC00000, 64'h7F800001,
                             64'h7FF0000000000000};
    logic [76:0] exp [5] = '{{1'b1, 13'd0,    53'd0,              6'd0, 4'b1000},
                             {1'b0, 13'd128,  ONE,                6'd0, 4'b0100},
                             {1'b0, 13'd128,  53'h18000000000000, 6'd0, 4'b0010},
                             {1'b0, 13'd128,  53'h10000020000000, 6'd0, 4'b0011},
                             {1'b0, 13'd1024, ONE,                6'd0, 4'b0100}};
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(d[i], op[i], lat);
      checks++;
      if (lat !== 1) begin
        errors++;
        $display("FAIL special_latency[%0d]: got %0d cycles required 1", i, lat);
      end
      checks++;
      if ({s, e, f, lz, ZERO, INF, NAN, SNAN} !== exp[i]) begin
        errors++;
        $display("FAIL special_fields[%0d]: got s=%b e=%h f=%h lz=%0d flags=%b required %h",
                 i, s, e, f, lz, {ZERO, INF, NAN, SNAN}, exp[i]);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic [76:0] held = {1'b0, 13'd0, ONE, 6'd0, 4'b0000};
    int lat;
    run_op(1'b0, 64'h3F800000, lat);
    db = 1'b0;
    operand = 64'h40000000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b10 || {s, e, f, lz, ZERO, INF, NAN, SNAN} !== held) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got valid/ready=%b e=%h f=%h required 10 e=0 f=%h",
                 i, {out_valid, in_ready}, e, f, ONE);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL backpressure_release: got valid/ready=%b required 01", {out_valid, in_ready});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || e !== 13'd1 || f !== ONE) begin
      errors++;
      $display("FAIL backpressure_next: got valid=%b e=%h f=%h required 1 e=0001 f=%h",
               out_valid, e, f, ONE);
    end
    release_result();
  endtask

  task automatic test_reset_mid_norm();
    int lat;
    db = 1'b1;
    operand = 64'h1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01 || f !== 53'd0 || lz !== 6'd0) begin
      errors++;
      $display("FAIL reset_mid_norm: got valid/ready=%b f=%h lz=%0d required 01 f=0 lz=0",
               {out_valid, in_ready}, f, lz);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(1'b1, 64'h3FF0000000000000, lat);
    checks++;
    if (lat !== 1 || {s, e, f, lz, ZERO, INF, NAN, SNAN} !== {1'b0, 13'd0, ONE, 6'd0, 4'b0000}) begin
      errors++;
      $display("FAIL after_reset_op: got lat=%0d e=%h f=%h lz=%0d required lat=1 e=0 f=%h lz=0",
               lat, e, f, lz, ONE);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_denormal();
    test_specials();
    test_backpressure();
    test_reset_mid_norm();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
